// File: rtl/led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
// Shared types for the LED count controller. It holds the command opcodes and
// the controller state encoding. The encodings are visible at the ports
// (cmd_op, ctrl_state), so they are pinned explicitly here.
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_RUN   = 2'b00,
        OP_PAUSE = 2'b01,
        OP_STEP  = 2'b10,
        OP_LOAD  = 2'b11
    } cmd_op_t;

    // Controller states reported on ctrl_state. 2'b11 is unused.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } ctrl_state_t;

endpackage : led_ctrl_pkg

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Rising-edge detector for the slow divided_clk level. It is sampled in the
// clk domain, so it produces a one-clk-wide pulse for each low-to-high
// transition of the level.
//
// Ports
//   clk   in   system clock
//   reset in   synchronous active-low reset
//   level in   slow level to watch (divided_clk)
//   rise  out  level && !prev_clk, combinational from the registered history
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_clk;

    // prev_clk resets high. If level is already high when reset releases, it
    // therefore does not produce a spurious edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_clk <= 1'b1;
        end else begin
            prev_clk <= level;
        end
    end

    assign rise = level && !prev_clk;

endmodule : rise_detect

// File: rtl/led_count_ctrl.sv
// -----------------------------------------------------------------------------
// led_count_ctrl
// Up/down LED counter. Each rising edge of divided_clk is one count tick. A
// small command FSM controls the counter: IDLE ignores ticks, RUN counts every
// tick, and STEP counts exactly one tick and then returns to IDLE. LOAD
// overwrites the count. The count either wraps or saturates at the terminal
// value for the current direction. A tick taken at the terminal value raises
// term_pulse for one cycle.
//
// Ports
//   clk         in   system clock; all state changes on posedge
//   reset       in   synchronous active-low reset
//   divided_clk in   slow level; each rising edge is one tick
//   cmd_valid   in   command request
//   cmd_op      in   00 RUN, 01 PAUSE, 10 STEP, 11 LOAD
//   cmd_arg     in   load value (LOAD only)
//   cmd_ready   out  high in IDLE and RUN, low in STEP
//   count_up    in   1 increment, 0 decrement (sampled per tick)
//   sat_mode    in   1 saturate, 0 wrap (sampled per tick)
//   led_count   out  registered count
//   ctrl_state  out  IDLE 00, RUN 01, STEP 10
//   term_pulse  out  one-cycle pulse after a tick taken at the terminal value
// -----------------------------------------------------------------------------
module led_count_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divided_clk,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             cmd_ready,
    input  logic             count_up,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] led_count,
    output logic [1:0]       ctrl_state,
    output logic             term_pulse
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    // Next count for one tick. Wrap and saturation are handled at both ends.
    function automatic logic [WIDTH-1:0] step_count(
        input logic [WIDTH-1:0] cur,
        input logic             up,
        input logic             sat
    );
        if (up) begin
            if (cur == MAX_COUNT) return sat ? MAX_COUNT : '0;
            return cur + ONE;
        end
        if (cur == '0) return sat ? '0 : MAX_COUNT;
        return cur - ONE;
    endfunction

    ctrl_state_t state;
    cmd_op_t     op;
    logic        tick;
    logic        cmd_accept;
    logic        load_accept;
    logic        tick_taken;
    logic        at_terminal;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .level (divided_clk),
        .rise  (tick)
    );

    assign op          = cmd_op_t'(cmd_op);
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign load_accept = cmd_accept && (op == OP_LOAD);

    // A tick counts only in RUN or STEP. An accepted LOAD in the same cycle
    // takes priority, and that tick is dropped. LOAD cannot be accepted in
    // STEP, because cmd_ready is low there.
    assign tick_taken  = tick && (state != ST_IDLE) && !load_accept;
    assign at_terminal = count_up ? (led_count == MAX_COUNT) : (led_count == '0);

    assign ctrl_state  = state;

    // One-process FSM. cmd_ready is registered next to the state, so it is a
    // clean flop output that is always equal to (state != ST_STEP).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            led_count  <= '0;
            term_pulse <= 1'b0;
        end else begin
            term_pulse <= tick_taken && at_terminal;

            if (load_accept) begin
                led_count <= cmd_arg;
            end else if (tick_taken) begin
                led_count <= step_count(led_count, count_up, sat_mode);
            end

            unique case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        unique case (op)
                            OP_RUN: begin
                                state     <= ST_RUN;
                                cmd_ready <= 1'b1;
                            end
                            OP_STEP: begin
                                state     <= ST_STEP;
                                cmd_ready <= 1'b0;
                            end
                            OP_PAUSE, OP_LOAD: begin
                                state     <= ST_IDLE;
                                cmd_ready <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_RUN: begin
                    if (cmd_accept) begin
                        unique case (op)
                            OP_PAUSE: begin
                                state     <= ST_IDLE;
                                cmd_ready <= 1'b1;
                            end
                            OP_STEP: begin
                                state     <= ST_STEP;
                                cmd_ready <= 1'b0;
                            end
                            OP_RUN, OP_LOAD: begin
                                state     <= ST_RUN;
                                cmd_ready <= 1'b1;
                            end
                        endcase
                    end
                end

                // The first tick is counted (via tick_taken above). The state
                // returns to IDLE in that same update.
                ST_STEP: begin
                    if (tick) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : led_count_ctrl

// File: tb/tb_led_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_count_ctrl
// Self-checking bench for led_count_ctrl (WIDTH = 8). It has three parts: a
// table of directed cycle-by-cycle vectors, a hand-written reset sequence,
// and randomized traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_led_count_ctrl;
    import led_ctrl_pkg::*;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk         = 1'b0;
    logic         reset       = 1'b0;
    logic         divided_clk = 1'b0;
    logic         cmd_valid   = 1'b0;
    logic [1:0]   cmd_op      = 2'b00;
    logic [W-1:0] cmd_arg     = '0;
    logic         count_up    = 1'b1;
    logic         sat_mode    = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] led_count;
    logic [1:0]   ctrl_state;
    logic         term_pulse;

    int errors = 0;
    int checks = 0;

    // Behavioural model. mode: 0 idle, 1 run, 2 step.
    int m_count = 0;
    int m_mode  = 0;
    bit m_prev  = 1'b1;
    bit m_term  = 1'b0;

    led_count_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .divided_clk (divided_clk),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .cmd_ready   (cmd_ready),
        .count_up    (count_up),
        .sat_mode    (sat_mode),
        .led_count   (led_count),
        .ctrl_state  (ctrl_state),
        .term_pulse  (term_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advances the model by one clock, using the inputs that are applied now.
    task automatic model_update();
        bit tick, accepted, is_load, counted;
        if (!reset) begin
            m_count = 0;
            m_mode  = 0;
            m_prev  = 1'b1;
            m_term  = 1'b0;
        end else begin
            tick     = divided_clk && !m_prev;
            m_prev   = divided_clk;
            accepted = cmd_valid && (m_mode != 2);
            is_load  = accepted && (cmd_op == 2'b11);
            counted  = tick && (m_mode != 0) && !is_load;
            m_term   = counted && (count_up ? (m_count == MAXV) : (m_count == 0));
            if (is_load) begin
                m_count = int'(cmd_arg);
            end else if (counted) begin
                if (count_up) m_count = (m_count == MAXV) ? (sat_mode ? MAXV : 0) : m_count + 1;
                else          m_count = (m_count == 0) ? (sat_mode ? 0 : MAXV) : m_count - 1;
            end
            if (m_mode == 2) begin
                if (tick) m_mode = 0;
            end else if (accepted) begin
                case (cmd_op)
                    2'b00:   m_mode = 1;
                    2'b01:   m_mode = 0;
                    2'b10:   m_mode = 2;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit r, input bit d, input bit v, input bit [1:0] op,
                          input bit [7:0] arg, input bit up, input bit sat);
        reset = r; divided_clk = d; cmd_valid = v; cmd_op = op;
        cmd_arg = arg; count_up = up; sat_mode = sat;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, 32'(led_count),  32'(m_count));
        check({tag, "_state"}, 32'(ctrl_state), 32'(m_mode));
        check({tag, "_ready"}, 32'(cmd_ready),  32'(m_mode != 2));
        check({tag, "_term"},  32'(term_pulse), 32'(m_term));
    endtask

    task automatic check_exp(input string tag, input bit [7:0] cnt, input bit [1:0] st,
                             input bit rdy, input bit term);
        check({tag, "_count"}, 32'(led_count),  32'(cnt));
        check({tag, "_state"}, 32'(ctrl_state), 32'(st));
        check({tag, "_ready"}, 32'(cmd_ready),  32'(rdy));
        check({tag, "_term"},  32'(term_pulse), 32'(term));
    endtask

    typedef struct {
        bit       rst;
        bit       d;
        bit       v;
        bit [1:0] op;
        bit [7:0] arg;
        bit       up;
        bit       sat;
        bit [7:0] cnt;
        bit [1:0] st;
        bit       rdy;
        bit       term;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst d v op arg up sat | cnt st rdy term  (expected after the edge)
        vecs.push_back('{0,0,0,2'd0,8'h00,1,0, 8'h00,2'd0,1,0}); // reset
        vecs.push_back('{1,0,1,2'd0,8'h00,1,0, 8'h00,2'd1,1,0}); // RUN
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h01,2'd1,1,0}); // 5 up ticks
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h01,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h02,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h02,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h03,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h03,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h04,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h04,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h05,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h05,2'd1,1,0});
        vecs.push_back('{1,0,1,2'd3,8'hFE,1,0, 8'hFE,2'd1,1,0}); // LOAD FE
        vecs.push_back('{1,0,1,2'd0,8'h00,1,0, 8'hFE,2'd1,1,0}); // RUN
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'hFF,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'hFF,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h00,2'd1,1,1}); // wrap up
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h00,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h01,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h01,2'd1,1,0});
        vecs.push_back('{1,0,1,2'd3,8'h01,0,1, 8'h01,2'd1,1,0}); // LOAD 01, down, sat
        vecs.push_back('{1,0,1,2'd0,8'h00,0,1, 8'h01,2'd1,1,0}); // RUN
        vecs.push_back('{1,1,0,2'd0,8'h00,0,1, 8'h00,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,0,1, 8'h00,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,0,1, 8'h00,2'd1,1,1}); // hold at 0
        vecs.push_back('{1,0,0,2'd0,8'h00,0,1, 8'h00,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,0,1, 8'h00,2'd1,1,1});
        vecs.push_back('{1,0,0,2'd0,8'h00,0,1, 8'h00,2'd1,1,0});
        vecs.push_back('{1,0,1,2'd1,8'h00,1,0, 8'h00,2'd0,1,0}); // PAUSE -> IDLE
        vecs.push_back('{1,0,1,2'd2,8'h00,1,0, 8'h00,2'd2,0,0}); // STEP
        vecs.push_back('{1,0,1,2'd0,8'h00,1,0, 8'h00,2'd2,0,0}); // RUN ignored
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h01,2'd0,1,0}); // step tick
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h01,2'd0,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h01,2'd0,1,0}); // idle tick dropped
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h01,2'd0,1,0});
        vecs.push_back('{1,0,1,2'd0,8'h00,1,0, 8'h01,2'd1,1,0}); // RUN
        vecs.push_back('{1,1,1,2'd3,8'h40,1,0, 8'h40,2'd1,1,0}); // LOAD beats tick
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h40,2'd1,1,0});
        vecs.push_back('{1,1,0,2'd0,8'h00,1,0, 8'h41,2'd1,1,0});
        vecs.push_back('{1,0,0,2'd0,8'h00,1,0, 8'h41,2'd1,1,0});
        vecs.push_back('{1,0,1,2'd3,8'hFF,1,1, 8'hFF,2'd1,1,0}); // LOAD FF, sat up
        vecs.push_back('{1,1,0,2'd0,8'h00,1,1, 8'hFF,2'd1,1,1}); // hold at FF
        vecs.push_back('{1,0,0,2'd0,8'h00,1,1, 8'hFF,2'd1,1,0});

        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].d, vecs[i].v, vecs[i].op, vecs[i].arg,
                   vecs[i].up, vecs[i].sat);
            cycle();
            check_exp($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].st, vecs[i].rdy, vecs[i].term);
        end

        // divided_clk is held high through reset and its release: no tick.
        set_in(0, 1, 0, 2'd0, 8'h00, 1, 0);
        cycle();
        cycle();
        check_exp("rst_hold", 8'h00, 2'd0, 1, 0);
        set_in(1, 1, 1, 2'd0, 8'h00, 1, 0);
        cycle();
        check_exp("rst_release", 8'h00, 2'd1, 1, 0);
        set_in(1, 1, 0, 2'd0, 8'h00, 1, 0);
        cycle();
        check_exp("rst_high_level", 8'h00, 2'd1, 1, 0);
        divided_clk = 1'b0;
        cycle();
        divided_clk = 1'b1;
        cycle();
        check_exp("post_rst_tick", 8'h01, 2'd1, 1, 0);
        divided_clk = 1'b0;
        cycle();
        // Reset mid-RUN, arriving together with a tick.
        set_in(0, 1, 0, 2'd0, 8'h00, 1, 0);
        cycle();
        check_exp("mid_run_rst", 8'h00, 2'd0, 1, 0);
        set_in(1, 0, 0, 2'd0, 8'h00, 1, 0);
        cycle();
        check_exp("after_mid_rst", 8'h00, 2'd0, 1, 0);

        // Randomized traffic against the model. LOAD values favour the edges.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) != 0);
            divided_clk = 1'($urandom_range(0, 1));
            cmd_valid   = ($urandom_range(0, 3) == 0);
            cmd_op      = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       cmd_arg = 8'h00;
                1:       cmd_arg = 8'h01;
                2:       cmd_arg = 8'hFE;
                3:       cmd_arg = 8'hFF;
                default: cmd_arg = 8'($urandom);
            endcase
            count_up = 1'($urandom_range(0, 1));
            sat_mode = 1'($urandom_range(0, 1));
            cycle();
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_led_count_ctrl

// File: doc/led_count_ctrl.md
LED_COUNT_CTRL -- requirements
Module: led_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets counter width in bits.
REQ-002 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-003 Port clk  in  1  single clock; all state changes on posedge clk.
REQ-004 Port reset  in  1  synchronous, active-low reset.
REQ-005 Port divided_clk  in  1  slow level from the clock divider; each rising edge is one count tick.
REQ-006 Port cmd_valid  in  1  command request.
REQ-007 Port cmd_op  in  2  command: 00 RUN, 01 PAUSE, 10 STEP, 11 LOAD.
REQ-008 Port cmd_arg  in  WIDTH  load value, used only by LOAD.
REQ-009 Port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-010 Port count_up  in  1  direction: 1 increment, 0 decrement; sampled on each tick.
REQ-011 Port sat_mode  in  1  1 saturate at terminal value, 0 wrap; sampled on each tick.
REQ-012 Port led_count  out  WIDTH  registered count, drives LEDs.
REQ-013 Port ctrl_state  out  2  current state encoding (IDLE 00, RUN 01, STEP 10).
REQ-014 Port term_pulse  out  1  one-cycle registered pulse on a tick taken at a terminal value.

Function
REQ-015 tick SHALL be divided_clk && !prev_clk; prev_clk SHALL register divided_clk every cycle.
REQ-016 The block SHALL count a tick only in RUN or STEP; ticks in IDLE are discarded.
REQ-017 Up tick: led_count+1; at 2^WIDTH-1, SHALL wrap to 0 (sat_mode=0) or hold (sat_mode=1).
REQ-018 Down tick: led_count-1; at 0, SHALL wrap to 2^WIDTH-1 (sat_mode=0) or hold (sat_mode=1).
REQ-019 term_pulse SHALL assert in the cycle after a tick is taken while led_count is at the terminal value for the current direction, in both modes.
REQ-020 cmd_ready SHALL be 1 in IDLE and RUN and 0 in STEP.
REQ-021 IDLE transitions: RUN to RUN, STEP to STEP, PAUSE stays in IDLE, LOAD stays in IDLE.
REQ-022 RUN transitions: PAUSE to IDLE, STEP to STEP, RUN stays in RUN, LOAD stays in RUN.
REQ-023 In STEP, the first tick SHALL count once and the state SHALL return to IDLE in the same update.
REQ-024 An accepted LOAD SHALL set led_count to cmd_arg next cycle, overriding any same-cycle tick; that tick is dropped.
REQ-025 Other accepted commands SHALL change state next cycle; a same-cycle tick is counted per the current state.
REQ-026 Commands with cmd_valid=1 and cmd_ready=0 SHALL be ignored, not queued.
REQ-027 Count latency: led_count SHALL update one clk after the cycle in which tick is detected.

Reset
REQ-028 While reset=0 at posedge: led_count=0, ctrl_state=IDLE, term_pulse=0, prev_clk=1.
REQ-029 Setting prev_clk=1 SHALL ensure divided_clk high at reset release produces no tick.
REQ-030 Reset during STEP or RUN SHALL abandon the operation and discard any pending tick.
REQ-031 cmd_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 Package led_ctrl_pkg SHALL hold the cmd_op enum and the ctrl_state enum, including their encodings.
REQ-033 Sub-module rise_detect SHALL implement REQ-015, including its prev_clk reset value; it is the only sub-module.
REQ-034 The counter, FSM and term_pulse logic SHALL reside in led_count_ctrl.

Verification
REQ-035 Reset, RUN, 5 divided_clk rising edges, count_up=1 -> led_count 5; cmd_ready always 1.
REQ-036 LOAD 8'hFE, RUN, 3 ticks, sat_mode=0 -> FF, 00 (term_pulse 1 cycle), 01.
REQ-037 LOAD 8'h01, count_up=0, sat_mode=1, RUN, 3 ticks -> 00, 00, 00; term_pulse on ticks 2 and 3.
REQ-038 IDLE, STEP, then RUN asserted before the tick -> RUN ignored (cmd_ready=0); one tick -> count+1, state IDLE; next tick -> no change.
REQ-039 RUN, LOAD 8'h40 in the same cycle as a tick -> led_count 40, tick dropped; next tick -> 41.
REQ-040 divided_clk held high through reset release -> no count; mid-RUN reset=0 -> led_count 0, state IDLE.
